// File: rtl/crc32_checker.sv
// crc32_checker: receives a frame byte-by-byte and checks its trailing CRC-32/MPEG-2
module crc32_checker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        d_valid,
    input  logic        d_finish,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        crc_valid,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [31:0] crc_calc,
    output logic [31:0] rx_crc
);
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t      state, state_nxt;
    logic [31:0] crc_reg, dly;
    logic [15:0] cnt;
    logic        acc, arm, match_ok;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'd0};
        for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    assign busy     = state != IDLE;
    assign arm      = load && state != CHECK;
    assign acc      = state == RECV && d_valid && !load;
    assign match_ok = cnt >= 16'd5 && crc_reg == dly;

    // next state: load arms from IDLE or re-arms from RECV, finish byte enters CHECK
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = load ? RECV : IDLE;
            RECV:    state_nxt = load ? RECV : (d_valid && d_finish) ? CHECK : RECV;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // datapath: the delay line hides the last 4 bytes (the CRC) from the engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg   <= 32'hFFFF_FFFF;
            dly       <= '0;
            cnt       <= '0;
            crc_valid <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            crc_calc  <= '0;
            rx_crc    <= '0;
        end else begin
            crc_valid <= 1'b0;
            if (arm) begin
                crc_reg  <= 32'hFFFF_FFFF;
                dly      <= '0;
                cnt      <= '0;
                crc_ok   <= 1'b0;
                crc_err  <= 1'b0;
                len_err  <= 1'b0;
                crc_calc <= '0;
                rx_crc   <= '0;
            end else if (acc) begin
                dly <= {dly[23:0], data_in};
                if (cnt >= 16'd4) crc_reg <= crc_byte(crc_reg, dly[31:24]);
                if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            end else if (state == CHECK) begin
                crc_calc  <= crc_reg;
                rx_crc    <= dly;
                len_err   <= cnt < 16'd5;
                crc_ok    <= match_ok;
                crc_err   <= !match_ok;
                crc_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_crc32_checker.sv
// tb_crc32_checker: randomized scoreboard bench against a bit-serial CRC reference
module tb_crc32_checker;
    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic        ok;
        logic        err;
        logic        len;
        logic [31:0] calc;
        logic [31:0] rx;
    } res_t;

    logic        clk = 0, rst_n = 0, load = 0, d_valid = 0, d_finish = 0;
    logic [7:0]  data_in = 0;
    logic        busy, crc_valid, crc_ok, crc_err, len_err;
    logic [31:0] crc_calc, rx_crc;
    int          errors = 0, checks = 0;
    res_t        exp_q[$];
    logic        prev_valid = 0;

    crc32_checker dut (
        .clk(clk), .rst_n(rst_n), .load(load), .d_valid(d_valid), .d_finish(d_finish),
        .data_in(data_in), .busy(busy), .crc_valid(crc_valid), .crc_ok(crc_ok),
        .crc_err(crc_err), .len_err(len_err), .crc_calc(crc_calc), .rx_crc(rx_crc)
    );

    always #5 clk = ~clk;

    // reference CRC-32/MPEG-2 as a one-bit-at-a-time LFSR over the first n bytes
    function automatic logic [31:0] ref_crc(input bq_t b, input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic        fb;
        for (int i = 0; i < n; i++)
            for (int k = 7; k >= 0; k--) begin
                fb = c[31] ^ b[i][k];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        return c;
    endfunction

    // expected result of a whole frame from its length and contents
    function automatic res_t model(input bq_t b);
        res_t r;
        int   n = b.size();
        r.rx = 0;
        for (int i = (n > 4 ? n - 4 : 0); i < n; i++) r.rx = {r.rx[23:0], b[i]};
        r.calc = ref_crc(b, n > 4 ? n - 4 : 0);
        r.len  = n < 5;
        r.ok   = !r.len && r.calc == r.rx;
        r.err  = !r.ok;
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: every crc_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && crc_valid) begin
            res_t e;
            if (exp_q.size() == 0) check("unexpected_valid", 96'd1, 96'd0);
            else begin
                e = exp_q.pop_front();
                check("result", {crc_ok, crc_err, len_err, crc_calc, rx_crc}, {e.ok, e.err, e.len, e.calc, e.rx});
            end
            check("ok_err_exclusive", {95'd0, crc_ok && crc_err}, 96'd0);
            if (prev_valid) check("valid_one_cycle", 96'd1, 96'd0);
        end
        prev_valid = crc_valid;
    end

    task automatic put_byte(input logic [7:0] b, input logic fin, input int gap_pct);
        while ($urandom_range(99) < gap_pct) begin
            d_valid  = 0;
            d_finish = $urandom_range(1);
            data_in  = $urandom;
            @(negedge clk);
        end
        d_valid  = 1;
        d_finish = fin;
        data_in  = b;
        @(negedge clk);
        d_valid  = 0;
        d_finish = 0;
    endtask

    task automatic send_frame(input bq_t b, input int gap_pct, input bit load_in_check);
        exp_q.push_back(model(b));
        load    = 1;
        d_valid = 1;
        data_in = 8'hAA;
        @(negedge clk);
        load    = 0;
        d_valid = 0;
        for (int i = 0; i < b.size(); i++) put_byte(b[i], i == b.size() - 1, gap_pct);
        check("check_state", {94'd0, busy, crc_valid}, {94'd0, 1'b1, 1'b0});
        load = load_in_check;
        @(negedge clk);
        load = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain", {64'd0, 32'(exp_q.size())}, 96'd0);
        exp_q.delete();
    endtask

    function automatic bq_t good_frame();
        bq_t b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h03, 8'h76, 8'hE6, 8'hE7};
        return b;
    endfunction

    initial begin
        bq_t b;
        res_t r;
        #1;
        check("reset_outputs", {busy, crc_valid, crc_ok, crc_err, len_err, crc_calc, rx_crc}, 96'd0 >> 29);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        b = good_frame();
        r = model(b);
        check("ref_check_value", {64'd0, r.calc}, {64'd0, 32'h0376_E6E7});
        send_frame(b, 0, 0);
        drain();
        check("good_hold", {crc_ok, crc_err, len_err, crc_calc, rx_crc}, {3'b100, 32'h0376_E6E7, 32'h0376_E6E7});

        b[12] = 8'hE6;
        send_frame(b, 0, 0);
        drain();
        check("corrupt_hold", {crc_ok, crc_err, len_err, crc_calc, rx_crc}, {3'b010, 32'h0376_E6E7, 32'h0376_E6E6});

        b = '{8'h11, 8'h22, 8'h33};
        send_frame(b, 0, 0);
        drain();
        check("short_len", {93'd0, crc_ok, crc_err, len_err}, {93'd0, 3'b011});

        b = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(b, 0, 0);
        drain();
        b = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        b[1] = 8'h00;
        r = model(b);
        b[1] = r.calc[31:24]; b[2] = r.calc[23:16]; b[3] = r.calc[15:8]; b[4] = r.calc[7:0];
        send_frame(b, 0, 0);
        drain();

        send_frame(good_frame(), 40, 0);
        drain();

        load = 1;
        @(negedge clk);
        load = 0;
        b = good_frame();
        for (int i = 0; i < 5; i++) put_byte(b[i], 0, 20);
        check("abort_busy", {95'd0, busy}, {95'd0, 1'b1});
        send_frame(good_frame(), 10, 1);
        drain();
        check("load_in_check_ignored", {95'd0, busy}, 96'd0);

        load = 1;
        @(negedge clk);
        load = 0;
        for (int i = 0; i < 6; i++) put_byte(b[i], 0, 0);
        #2 rst_n = 0;
        #1 check("midframe_reset", {busy, crc_valid, crc_ok, crc_err, len_err, crc_calc, rx_crc}, 96'd0 >> 29);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) put_byte(b[i], i == 7, 0);
        repeat (3) @(negedge clk);
        check("idle_ignores_data", {95'd0, busy}, 96'd0);

        for (int f = 0; f < 25; f++) begin
            int n = $urandom_range(1, 20);
            b = {};
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            if ($urandom_range(1)) begin
                r.calc = ref_crc(b, n);
                for (int k = 3; k >= 0; k--) b.push_back(r.calc[k*8 +: 8]);
            end
            send_frame(b, $urandom_range(50), 0);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/crc32_checker.md
CRC32_CHECKER -- requirements
Module: crc32_checker

Interface
REQ-001 The block SHALL have a single clock and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 load  input  1  start-of-frame strobe; arms the checker for a new frame.
REQ-005 d_valid  input  1  data_in holds a valid frame byte this cycle.
REQ-006 d_finish  input  1  qualifies the current valid byte as the last byte of the frame.
REQ-007 data_in  input  8  frame byte, MSB first on the wire.
REQ-008 busy  output  1  high while a frame is being received or checked.
REQ-009 crc_valid  output  1  one-cycle pulse marking the check result as available.
REQ-010 crc_ok  output  1  frame passed: length is legal and the CRCs match.
REQ-011 crc_err  output  1  frame failed: CRC mismatch or illegal length.
REQ-012 len_err  output  1  frame was shorter than 5 bytes.
REQ-013 crc_calc  output  32  CRC computed over the payload bytes.
REQ-014 rx_crc  output  32  received CRC, taken from the last 4 frame bytes, first byte = bits [31:24].

Function
REQ-015 Frame format SHALL be payload bytes (at least 1) followed by a 4-byte CRC, with the CRC MSB byte first.
REQ-016 The CRC algorithm SHALL be CRC-32/MPEG-2: poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected, byte MSB-first, no final XOR.
REQ-017 The CRC engine SHALL process one byte per accepted beat and SHALL be combinational 8-bit-parallel next-state logic.
REQ-018 States SHALL be IDLE, RECV and CHECK; reset state SHALL be IDLE.
REQ-019 IDLE->RECV SHALL occur on load; on that edge the CRC register is set to 0xFFFFFFFF, the delay line and byte count are cleared, and crc_ok, crc_err, len_err, crc_calc and rx_crc are cleared to 0.
REQ-020 In IDLE, d_valid and d_finish SHALL be ignored; the byte presented with load SHALL NOT be captured.
REQ-021 In RECV, each d_valid byte SHALL be shifted into a 4-byte delay line; once 4 bytes are held, the byte leaving the line SHALL be fed to the CRC engine.
REQ-022 The byte counter SHALL be 16 bits and SHALL saturate at 0xFFFF (no wrap).
REQ-023 d_valid low SHALL stall all state; gaps of any length between bytes SHALL be legal.
REQ-024 RECV->CHECK SHALL occur on the edge (E) that accepts a byte with d_valid=1 and d_finish=1; d_finish with d_valid=0 SHALL be ignored.
REQ-025 In CHECK, on edge E+1: crc_calc <= CRC register, rx_crc <= delay line, len_err <= (count<5), crc_ok <= !len_err && match, crc_err <= !crc_ok, crc_valid <= 1, state -> IDLE.
REQ-026 crc_valid SHALL be high exactly one cycle (E+1 to E+2); crc_ok, crc_err, len_err, crc_calc and rx_crc SHALL hold until the next load.
REQ-027 busy SHALL be 1 in RECV and CHECK and 0 in IDLE.
REQ-028 load in RECV SHALL abort the frame with no crc_valid pulse and re-arm per REQ-019; in CHECK, load SHALL be ignored.
REQ-029 crc_ok and crc_err SHALL never be 1 simultaneously.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, with all outputs 0, CRC register 0xFFFFFFFF, and delay line and count cleared.
REQ-031 A reset during RECV or CHECK SHALL discard the frame with no crc_valid pulse.
REQ-032 After rst_n deasserts, operation SHALL require a new load.

Verification
REQ-033 Good frame: load, then 0x31..0x39, 0x03, 0x76, 0xE6, 0xE7 (d_finish on 0xE7) -> crc_valid pulse at E+1, crc_ok=1, crc_calc=rx_crc=0x0376E6E7.
REQ-034 Corrupt frame: same as REQ-033 with last byte 0xE6 -> crc_err=1, crc_ok=0, rx_crc=0x0376E6E6, crc_calc=0x0376E6E7.
REQ-035 Short frame: load, 3 bytes with d_finish on the third -> len_err=1, crc_err=1, crc_ok=0.
REQ-036 Gapped stream: the REQ-033 frame with random d_valid=0 gaps -> identical result; d_finish with d_valid=0 mid-frame -> no effect.
REQ-037 Abort: load after 5 bytes, then the full REQ-033 frame -> exactly one crc_valid pulse, crc_ok=1.
REQ-038 Reset mid-frame: rst_n low after 6 bytes -> busy=0 and all outputs 0 immediately; no crc_valid pulse until the next load.
